// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port among NREQ writers: fixed-priority grant,
// valid/ready handshake, one registered output stage. Define REGARB_AGING_EN for anti-starvation aging.
module regfile_wport_arbiter #(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic [1:0]               grant_id,
    output logic                     busy
);

    if (NREQ < 2 || NREQ > 4 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_param
        $error("regfile_wport_arbiter: NREQ must be 2..4 and MAX_WAIT 1..15");
    end

    logic [NREQ-1:0]   aged;
    logic [NREQ-1:0]   cand;
    logic [1:0]        sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              grant;

`ifdef REGARB_AGING_EN
    logic [3:0] wait_cnt [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            aged[i] = req_valid[i] && (wait_cnt[i] >= 4'(MAX_WAIT));
        end
    end

    // NOTE: the counter array is control state, so every entry is reset; data-only
    // storage would not need this.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != 4'hF) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    assign aged = '0;
`endif

    // An aged valid requester pre-empts the plain priority order.
    assign cand  = (|aged) ? aged : req_valid;
    assign grant = rst && !hold && (|req_valid);

    // NOTE: every output of this block gets a default first, so no latch is inferred
    // when no candidate is found.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_id   = 2'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && (sel_id == 2'(i));
        end
    end

    assign busy = rst && (|req_valid) && !(|(req_valid & req_ready));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            grant_id <= '0;
        end else if (grant) begin
            we       <= (sel_addr != '0);
            waddr    <= sel_addr;
            wdata    <= sel_data;
            grant_id <= sel_id;
        end else begin
            we       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter (NREQ=2) against a behavioural model of
// the grant, output-stage and (with REGARB_AGING_EN) aging rules.
module tb_regfile_wport_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [1:0]  m_gid;
    int          wt [2];
    logic [1:0]  exp_ready, obs_ready;
    logic        exp_busy, obs_busy;

    regfile_wport_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = '0;
        wt[0] = 0; wt[1] = 0;
    endfunction

    function automatic logic [1:0] model_ready();
        if (!rst || hold || req_valid == 2'b00) return 2'b00;
`ifdef REGARB_AGING_EN
        if (req_valid[0] && wt[0] >= MAX_WAIT) return 2'b01;
        if (req_valid[1] && wt[1] >= MAX_WAIT) return 2'b10;
`endif
        return req_valid[0] ? 2'b01 : 2'b10;
    endfunction

    // One clock: sample combinational outputs, advance the model across the edge.
    task automatic cycle();
        logic [1:0] tr;
        int idx;
        #1;
        exp_ready = model_ready();
        exp_busy  = rst && (req_valid != 2'b00) && ((req_valid & exp_ready) == 2'b00);
        obs_ready = req_ready;
        obs_busy  = busy;
        @(posedge clk);
        tr = req_valid & exp_ready;
        if (!rst) begin
            model_reset();
        end else begin
            if (tr != 2'b00) begin
                idx     = tr[1] ? 1 : 0;
                m_waddr = req_addr[idx*5 +: 5];
                m_wdata = req_data[idx*32 +: 32];
                m_we    = (m_waddr != 5'd0);
                m_gid   = 2'(idx);
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || tr[i]) wt[i] = 0;
                else if (wt[i] < 15) wt[i] = wt[i] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        req_valid = 2'b11; req_addr = {5'd7, 5'd3}; req_data = {32'h1111_2222, 32'h3333_4444};
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        checks++; if (waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h/%h expected 0/0", waddr, wdata); end
        checks++; if (grant_id !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_gid_busy: got %0d/%b expected 0/0", grant_id, busy); end
        req_valid = 2'b00;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req_valid = 2'b10; req_addr = {5'd5, 5'd0}; req_data = {32'hDEADBEEF, 32'h0};
        cycle();
        checks++; if (obs_ready !== 2'b10 || obs_ready !== exp_ready) begin errors++; $display("FAIL single_ready: got %b expected 10", obs_ready); end
        checks++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || grant_id !== 2'd1)
            begin errors++; $display("FAIL single_write: got we=%b a=%0d d=%h g=%0d expected 1/5/deadbeef/1", we, waddr, wdata, grant_id); end
        req_valid = 2'b00;
        cycle();
        checks++; if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_after: got we=%b a=%0d d=%h expected 0/5/deadbeef", we, waddr, wdata); end
    endtask

    task automatic test_contention();
        req_valid = 2'b11; req_addr = {5'd7, 5'd3}; req_data = {32'hBBBB_0007, 32'hAAAA_0003};
        cycle();
        checks++; if (obs_ready !== 2'b01 || obs_busy !== 1'b0)
            begin errors++; $display("FAIL cont_first: got ready=%b busy=%b expected 01/0", obs_ready, obs_busy); end
        checks++; if (we !== 1'b1 || waddr !== 5'd3 || grant_id !== 2'd0)
            begin errors++; $display("FAIL cont_w0: got we=%b a=%0d g=%0d expected 1/3/0", we, waddr, grant_id); end
        req_valid = 2'b10;
        cycle();
        checks++; if (obs_ready !== 2'b10 || obs_busy !== 1'b0)
            begin errors++; $display("FAIL cont_second: got ready=%b busy=%b expected 10/0", obs_ready, obs_busy); end
        checks++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hBBBB_0007 || grant_id !== 2'd1)
            begin errors++; $display("FAIL cont_w1: got we=%b a=%0d d=%h g=%0d expected 1/7/bbbb0007/1", we, waddr, wdata, grant_id); end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_zero_hold();
        req_valid = 2'b01; req_addr = {5'd9, 5'd0}; req_data = {32'h0000_0009, 32'hFFFF_FFFF};
        cycle();
        checks++; if (obs_ready !== 2'b01) begin errors++; $display("FAIL zero_ready: got %b expected 01", obs_ready); end
        checks++; if (we !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL zero_we: got we=%b g=%0d expected 0/0", we, grant_id); end
        req_valid = 2'b10; hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (obs_ready !== 2'b00 || obs_busy !== 1'b1 || we !== 1'b0)
                begin errors++; $display("FAIL hold_block: got ready=%b busy=%b we=%b expected 00/1/0", obs_ready, obs_busy, we); end
        end
        hold = 1'b0;
        cycle();
        checks++; if (obs_ready !== 2'b10 || we !== 1'b1 || waddr !== 5'd9 || grant_id !== 2'd1)
            begin errors++; $display("FAIL hold_release: got ready=%b we=%b a=%0d g=%0d expected 10/1/9/1", obs_ready, we, waddr, grant_id); end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_aging();
        int granted_at = -1;
        req_valid = 2'b11; req_addr = {5'd12, 5'd4};
        for (int k = 1; k <= 20 && granted_at < 0; k++) begin
            req_data = {32'hC0DE_0000, 32'(k)};
            cycle();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL aging_ready: got %b expected %b", obs_ready, exp_ready); end
            if (obs_ready[1]) granted_at = k;
        end
`ifdef REGARB_AGING_EN
        checks++; if (granted_at != MAX_WAIT + 1) begin errors++; $display("FAIL aging_grant: got cycle %0d expected %0d", granted_at, MAX_WAIT + 1); end
`else
        checks++; if (granted_at != -1) begin errors++; $display("FAIL starve_grant: got cycle %0d expected none", granted_at); end
`endif
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; req_addr = {5'd0, 5'd17}; req_data = {32'h0, 32'h5A5A_5A5A};
        cycle();
        checks++; if (we !== 1'b1 || waddr !== 5'd17) begin errors++; $display("FAIL rmid_pre: got we=%b a=%0d expected 1/17", we, waddr); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (we !== 1'b0 || waddr !== 5'd0 || req_ready !== 2'b00 || busy !== 1'b0)
            begin errors++; $display("FAIL rmid_clear: got we=%b a=%0d ready=%b busy=%b expected 0/0/00/0", we, waddr, req_ready, busy); end
        req_valid = 2'b00;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        cycle();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rmid_after: got we=%b expected 0", we); end
    endtask

    task automatic test_random();
        logic [1:0] tr;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*5 +: 5] = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            hold = ($urandom_range(3, 0) == 0);
            cycle();
            checks++; if (obs_ready !== exp_ready || obs_busy !== exp_busy)
                begin errors++; $display("FAIL rand_hs[%0d]: got ready=%b busy=%b expected %b/%b", n, obs_ready, obs_busy, exp_ready, exp_busy); end
            checks++; if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata || grant_id !== m_gid)
                begin errors++; $display("FAIL rand_out[%0d]: got %b/%h/%h/%0d expected %b/%h/%h/%0d", n, we, waddr, wdata, grant_id, m_we, m_waddr, m_wdata, m_gid); end
            tr = req_valid & exp_ready;
            req_valid = req_valid & ~tr;
        end
        hold = 1'b0; req_valid = 2'b00;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_hold();
        test_aging();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
